// File: rtl/gbe_tx_sync_fifo.sv
// Single-clock FIFO for the GbE UDP transmit path (standard or FWFT read).
// Optional underflow pulse output enabled by GBE_TX_FIFO_UNDERFLOW_EN.
module gbe_tx_sync_fifo #(
    parameter int WIDTH            = 8,
    parameter int ADDR_W           = 11,
    parameter int PROG_FULL_THRESH = 1984,
    parameter int FWFT             = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             wr_en,
    input  logic             rd_en,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic             prog_full,
    output logic             overflow
`ifdef GBE_TX_FIFO_UNDERFLOW_EN
    ,
    output logic             underflow
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam int CNT_W = ADDR_W + 1;

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] THRESH_C = CNT_W'(PROG_FULL_THRESH);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  count;

    logic wr_acc;
    logic rd_acc;
    logic mem_we;
    logic mem_re;
    logic byp;

    assign empty     = (count == '0);
    assign full      = (count == DEPTH_C);
    assign prog_full = (count >= THRESH_C);

    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    generate
        if (FWFT != 0) begin : g_fwft
            // dout holds the head word; memory holds count-1 words.
            always_comb begin
                byp    = 1'b0;
                mem_re = 1'b0;
                mem_we = 1'b0;
                byp    = wr_acc &
                         ((count == '0) | (rd_acc & (count == ONE_C)));
                mem_re = rd_acc & (count > ONE_C);
                mem_we = wr_acc & ~byp;
            end
        end else begin : g_std
            assign byp    = 1'b0;
            assign mem_re = rd_acc;
            assign mem_we = wr_acc;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else begin
            unique case (1'b1)
                byp:     dout <= din;
                mem_re:  dout <= mem[rd_ptr];
                default: dout <= dout;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (mem_we) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (mem_re) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else begin
            overflow <= wr_en & full;
        end
    end

`ifdef GBE_TX_FIFO_UNDERFLOW_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            underflow <= 1'b0;
        end else begin
            underflow <= rd_en & empty;
        end
    end
`endif

endmodule

// File: tb/tb_gbe_tx_sync_fifo.sv
// Scoreboard bench: standard byte FIFO and a small 64-bit FWFT FIFO.
// Driver pushes per-cycle expectations; a negedge monitor pops and checks.
module tb_gbe_tx_sync_fifo;

    localparam int DA = 2048;
    localparam int TA = 1984;
    localparam int DB = 16;
    localparam int TB = 12;

    typedef struct packed {
        logic [63:0] dout;
        logic        dchk;
        logic        empty;
        logic        full;
        logic        pfull;
        logic        ovf;
        logic        udf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  din_a;
    logic        wr_a;
    logic        rd_a;
    logic [7:0]  dout_a;
    logic        empty_a;
    logic        full_a;
    logic        pfull_a;
    logic        ovf_a;
    logic        udf_a;
    logic [63:0] din_b;
    logic        wr_b;
    logic        rd_b;
    logic [63:0] dout_b;
    logic        empty_b;
    logic        full_b;
    logic        pfull_b;
    logic        ovf_b;
    logic        udf_b;

    int checks = 0;
    int errors = 0;

    exp_t qa[$];
    exp_t qb[$];
    logic [7:0]  mqa[$];
    logic [63:0] mqb[$];
    logic [7:0]  douta_m;

    always #5 clk = ~clk;

    gbe_tx_sync_fifo u_std (
        .clk       (clk),
        .rst       (rst),
        .din       (din_a),
        .wr_en     (wr_a),
        .rd_en     (rd_a),
        .dout      (dout_a),
        .empty     (empty_a),
        .full      (full_a),
        .prog_full (pfull_a),
        .overflow  (ovf_a)
`ifdef GBE_TX_FIFO_UNDERFLOW_EN
        ,
        .underflow (udf_a)
`endif
    );

    gbe_tx_sync_fifo #(
        .WIDTH            (64),
        .ADDR_W           (4),
        .PROG_FULL_THRESH (TB),
        .FWFT             (1)
    ) u_fwft (
        .clk       (clk),
        .rst       (rst),
        .din       (din_b),
        .wr_en     (wr_b),
        .rd_en     (rd_b),
        .dout      (dout_b),
        .empty     (empty_b),
        .full      (full_b),
        .prog_full (pfull_b),
        .overflow  (ovf_b)
`ifdef GBE_TX_FIFO_UNDERFLOW_EN
        ,
        .underflow (udf_b)
`endif
    );

`ifndef GBE_TX_FIFO_UNDERFLOW_EN
    assign udf_a = 1'b0;
    assign udf_b = 1'b0;
`endif

    task automatic chk1(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk(input string p, input exp_t e, input logic [63:0] d,
                       input logic em, input logic fu, input logic pf,
                       input logic ov, input logic ud);
        if (e.dchk) chk1({p, "_dout"}, d, e.dout);
        chk1({p, "_empty"}, 64'(em), 64'(e.empty));
        chk1({p, "_full"}, 64'(fu), 64'(e.full));
        chk1({p, "_prog_full"}, 64'(pf), 64'(e.pfull));
        chk1({p, "_overflow"}, 64'(ov), 64'(e.ovf));
`ifdef GBE_TX_FIFO_UNDERFLOW_EN
        chk1({p, "_underflow"}, 64'(ud), 64'(e.udf));
`else
        if (ud) chk1({p, "_underflow"}, 64'(ud), 64'(e.udf));
`endif
    endtask

    always @(negedge clk) begin
        if (qa.size() != 0) begin
            chk("std", qa.pop_front(), {56'b0, dout_a}, empty_a, full_a,
                pfull_a, ovf_a, udf_a);
        end
        if (qb.size() != 0) begin
            chk("fwft", qb.pop_front(), dout_b, empty_b, full_b,
                pfull_b, ovf_b, udf_b);
        end
    end

    task automatic step(input logic rs, input logic aw, input logic [7:0] ad,
                        input logic ar, input logic bw,
                        input logic [63:0] bd, input logic br);
        exp_t ea;
        exp_t eb;
        logic fpre;
        logic epre;
        ea = '0;
        eb = '0;
        rst = rs; wr_a = aw; din_a = ad; rd_a = ar;
        wr_b = bw; din_b = bd; rd_b = br;
        if (rs) begin
            mqa.delete();
            mqb.delete();
            douta_m = 8'h00;
        end else begin
            fpre = (mqa.size() == DA);
            epre = (mqa.size() == 0);
            ea.ovf = aw & fpre;
            ea.udf = ar & epre;
            if (ar && !epre) douta_m = mqa.pop_front();
            if (aw && !fpre) mqa.push_back(ad);
            fpre = (mqb.size() == DB);
            epre = (mqb.size() == 0);
            eb.ovf = bw & fpre;
            eb.udf = br & epre;
            if (br && !epre) void'(mqb.pop_front());
            if (bw && !fpre) mqb.push_back(bd);
        end
        ea.dout  = {56'b0, douta_m};
        ea.dchk  = 1'b1;
        ea.empty = (mqa.size() == 0);
        ea.full  = (mqa.size() == DA);
        ea.pfull = (mqa.size() >= TA);
        eb.dchk  = rs | (mqb.size() != 0);
        eb.dout  = (mqb.size() != 0) ? mqb[0] : 64'h0;
        eb.empty = (mqb.size() == 0);
        eb.full  = (mqb.size() == DB);
        eb.pfull = (mqb.size() >= TB);
        @(posedge clk);
        qa.push_back(ea);
        qb.push_back(eb);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wr_a = 1'b0; rd_a = 1'b0; din_a = '0;
        wr_b = 1'b0; rd_b = 1'b0; din_b = '0;
        douta_m = 8'h00;
        @(posedge clk);
        #1;
        step(1, 0, 8'h00, 0, 0, 64'h0, 0);
        step(1, 1, 8'h99, 1, 1, 64'h99, 1);
        step(0, 1, 8'h11, 0, 1, 64'h0010_1234_0A00_0001, 0);
        step(0, 1, 8'h22, 0, 0, 64'h0, 0);
        step(0, 1, 8'h33, 0, 0, 64'h0, 1);
        step(0, 0, 8'h00, 1, 0, 64'h0, 0);
        step(0, 0, 8'h00, 1, 0, 64'h0, 0);
        step(0, 0, 8'h00, 1, 0, 64'h0, 0);
        step(0, 0, 8'h00, 1, 0, 64'h0, 1);
        for (int i = 0; i < DA; i++) begin
            step(0, 1, 8'(i), 0, i < 18, 64'hA000 + 64'(i), 0);
        end
        step(0, 1, 8'hEE, 1, 1, 64'hBAD, 1);
        step(0, 0, 8'h00, 0, 0, 64'h0, 0);
        for (int i = 0; i < 5000; i++) begin
            step(0, 1, 8'(i), 1, 1, 64'hC_0000 + 64'(i), 1);
        end
        step(1, 0, 8'h00, 0, 0, 64'h0, 0);
        for (int i = 0; i < 10; i++) begin
            step(0, 1, 8'h40 + 8'(i), 0, 1, 64'hD0 + 64'(i), 0);
        end
        step(1, 0, 8'h00, 0, 0, 64'h0, 0);
        step(0, 0, 8'h00, 1, 0, 64'h0, 1);
        step(0, 0, 8'h00, 0, 0, 64'h0, 0);
        @(negedge clk);
        #1;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain act=%0d exp=0", qa.size() + qb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/gbe_tx_sync_fifo.md
Name: gbe_tx_sync_fifo

Overview:
- Single-clock, parameterised FIFO used twice in the GbE UDP transmit path.
- As the byte-wide packet-data FIFO (WIDTH=8, FWFT=0), it buffers application payload bytes.
- As the 64-bit control FIFO (WIDTH=64, FWFT=1), it holds one {size[15:0], destport[15:0], destip[31:0]} word per frame.
- Provides empty, full, programmable almost-full and a sticky-free overflow pulse to the transmit logic.

Parameters:
- WIDTH, 8, data word width in bits.
- ADDR_W, 11, log2 of depth; DEPTH = 2**ADDR_W entries (2048).
- PROG_FULL_THRESH, 1984, prog_full asserts when occupancy >= this value.
- FWFT, 0: 0 = standard read (dout valid one cycle after an accepted rd_en); 1 = first-word-fall-through.

Ports:
- clk, input, 1, sole clock; all logic on its rising edge.
- rst, input, 1, synchronous active-high reset.
- din, input, WIDTH, write data.
- wr_en, input, 1, write request.
- rd_en, input, 1, read request.
- dout, output, WIDTH, read data.
- empty, output, 1, no words available.
- full, output, 1, occupancy == DEPTH.
- prog_full, output, 1, occupancy >= PROG_FULL_THRESH.
- overflow, output, 1, one-cycle pulse flagging a rejected write.

Behaviour:
- State:
  - Write pointer and read pointer, ADDR_W bits each; both wrap modulo DEPTH.
  - Occupancy count, ADDR_W+1 bits, range 0..DEPTH.
  - Storage array of DEPTH x WIDTH.
- Reset (rst=1 at a clock edge):
  - Pointers = 0, count = 0, dout = 0.
  - empty = 1, full = 0, prog_full = 0, overflow = 0.
  - Memory contents are not cleared.
  - A reset mid-operation discards all stored words; wr_en/rd_en are ignored during that cycle.
- Flags:
  - full, prog_full and empty are decoded from the registered count (count==DEPTH, count>=PROG_FULL_THRESH, count==0).
  - In FWFT mode, empty is as defined in the FWFT bullet below.
  - All flags reflect state after the previous edge; no combinational path from wr_en/rd_en.
- Write:
  - Accepted when wr_en=1 and full=0: din is stored at the write pointer, which then increments.
  - When wr_en=1 and full=1 the write is dropped.
  - overflow=1 on the following cycle for exactly one cycle per dropped write; otherwise overflow=0.
  - full is sampled before the edge: a write while full is dropped even if a read is accepted in the same cycle.
- Read, standard mode (FWFT=0):
  - Accepted when rd_en=1 and empty=0.
  - dout <= mem[read pointer] on that edge, so data is valid the cycle after rd_en; the read pointer increments.
  - A read while empty is ignored; dout holds its value.
  - dout holds between reads.
- Read, FWFT mode (FWFT=1):
  - While empty=0, dout already presents the oldest word.
  - rd_en=1 with empty=0 pops that word; dout shows the next word (or empty rises) on the next cycle.
  - A word written into an empty FIFO at edge N appears on dout with empty=0 after edge N (latency 1).
  - rd_en while empty is ignored.
- Simultaneous accepted read and write: count unchanged; both pointers advance.
- Write into empty while rd_en=1: only the write takes effect that cycle.
- Ordering: strictly first-in first-out; no data loss except dropped overflow writes.
- Wrap-around: after DEPTH writes and reads, pointers return to 0 with no disturbance to ordering.

Optional Feature:
- Macro GBE_TX_FIFO_UNDERFLOW_EN.
- When defined: add output port underflow (1 bit), reset 0. It pulses high for one cycle following each cycle in which rd_en=1 while empty=1.
- When undefined: the port and its logic are absent; a read on empty is silently ignored.

Test Plan:
- Reset, then write 0x11,0x22,0x33 (FWFT=0), then rd_en 3 cycles -> dout = 0x11, 0x22, 0x33 on the cycles after each rd_en; empty=1 after the third read; overflow stays 0.
- Fill 2048 words -> full=1 at count 2048 and prog_full=1 from count 1984. A 2049th write with rd_en=1 in the same cycle -> write dropped, overflow=1 for one cycle, count=2047 after the read.
- FWFT=1, WIDTH=64: write 0x0010_1234_0A00_0001 -> next cycle empty=0 and dout shows that value before any rd_en. One rd_en -> empty=1 the cycle after.
- Continuous simultaneous read/write for 5000 cycles with an incrementing pattern -> count constant, output sequence matches input exactly across pointer wrap.
- Assert rst with 10 words stored -> next cycle empty=1, full=0, prog_full=0, dout=0. A subsequent rd_en yields no data change.
- With GBE_TX_FIFO_UNDERFLOW_EN: rd_en on an empty FIFO -> underflow=1 for one cycle, dout unchanged.
